// File: rtl/comm_master.sv
// comm_master: host-side command transmitter with a response receiver.
// TX sends a 3-byte frame (cmd, data[15:8], data[7:0]) as 8N1 UART bytes
// back-to-back; RX captures single response bytes and flags them with resp_rdy.
module comm_master #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        snd_cmd,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        frm_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_CMD = 2'd1,
        ST_SEND_HI  = 2'd2,
        ST_SEND_LO  = 2'd3
    } tx_state_e;

    // Line level for position idx of an 8N1 byte: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] j;
        logic       v;
        j = idx - 4'd1;
        if (idx == 4'd0) begin
            v = 1'b0;
        end else if (idx <= 4'd8) begin
            v = b[j[2:0]];
        end else begin
            v = 1'b1;
        end
        return v;
    endfunction

    // ---------------- transmitter ----------------
    tx_state_e        state_q, state_d;
    logic [15:0]      data_q, data_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_q, tx_d;
    logic             frm_snt_q, frm_snt_d;
    logic             tx_bit_end_s;
    logic             tx_byte_end_s;

    // Bit and byte boundary strobes for the transmit bit timer.
    always_comb begin
        tx_bit_end_s  = (tx_cnt_q == BAUD_LAST);
        tx_byte_end_s = tx_bit_end_s && (tx_bit_q == 4'd9);
    end

    // FSM state register; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one byte per sending state, advancing at the end of each stop bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (snd_cmd) begin
                    state_d = ST_SEND_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_CMD: begin
                if (tx_byte_end_s) begin
                    state_d = ST_SEND_HI;
                end else begin
                    state_d = ST_SEND_CMD;
                end
            end
            ST_SEND_HI: begin
                if (tx_byte_end_s) begin
                    state_d = ST_SEND_LO;
                end else begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_LO: begin
                if (tx_byte_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs and TX datapath: capture, bit timing, byte loading and the sticky frm_snt.
    always_comb begin
        data_d    = data_q;
        tx_byte_d = tx_byte_q;
        tx_bit_d  = tx_bit_q;
        tx_cnt_d  = tx_cnt_q;
        tx_d      = tx_q;
        frm_snt_d = frm_snt_q;
        case (state_q)
            ST_IDLE: begin
                if (snd_cmd) begin
                    data_d    = data;
                    tx_byte_d = cmd;
                    tx_bit_d  = 4'd0;
                    tx_cnt_d  = CNT_ZERO;
                    tx_d      = 1'b0;
                    frm_snt_d = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                if (tx_bit_end_s) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d = 4'd0;
                        case (state_q)
                            ST_SEND_CMD: begin
                                tx_byte_d = data_q[15:8];
                                tx_d      = 1'b0;
                            end
                            ST_SEND_HI: begin
                                tx_byte_d = data_q[7:0];
                                tx_d      = 1'b0;
                            end
                            default: begin
                                tx_d      = 1'b1;
                                frm_snt_d = 1'b1;
                            end
                        endcase
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = frame_bit(tx_byte_q, tx_bit_q + 4'd1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Transmit datapath registers; TX is held high by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= 16'h0000;
            tx_byte_q <= 8'h00;
            tx_bit_q  <= 4'd0;
            tx_cnt_q  <= CNT_ZERO;
            tx_q      <= 1'b1;
            frm_snt_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            tx_byte_q <= tx_byte_d;
            tx_bit_q  <= tx_bit_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_q      <= tx_d;
            frm_snt_q <= frm_snt_d;
        end
    end

    // ---------------- receiver ----------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             rx_busy_q, rx_busy_d;
    logic [3:0]       rx_bit_q, rx_bit_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       resp_q, resp_d;
    logic             resp_rdy_q, resp_rdy_d;
    logic             rx_start_s;
    logic             rx_done_s;

    // Receive sequencing: start detect, mid-bit sampling, glitch reject and byte completion.
    always_comb begin
        rx_busy_d  = rx_busy_q;
        rx_bit_d   = rx_bit_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        rx_done_s  = 1'b0;
        rx_start_s = (!rx_busy_q) && rx_prev_q && (!rx_sync_q);
        if (!rx_busy_q) begin
            if (rx_start_s) begin
                rx_busy_d = 1'b1;
                rx_bit_d  = 4'd0;
                rx_cnt_d  = HALF_LAST;
            end else begin
                rx_busy_d = 1'b0;
            end
        end else if (rx_cnt_q == CNT_ZERO) begin
            rx_cnt_d = BAUD_LAST;
            case (rx_bit_q)
                4'd0: begin
                    if (rx_sync_q) begin
                        rx_busy_d = 1'b0;
                    end else begin
                        rx_bit_d = 4'd1;
                    end
                end
                4'd9: begin
                    resp_d    = rx_shift_q;
                    rx_done_s = 1'b1;
                    rx_busy_d = 1'b0;
                end
                default: begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                end
            endcase
        end else begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
    end

    // resp_rdy: byte completion wins over clear requests and new start bits.
    always_comb begin
        if (rx_done_s) begin
            resp_rdy_d = 1'b1;
        end else if (clr_resp_rdy || rx_start_s) begin
            resp_rdy_d = 1'b0;
        end else begin
            resp_rdy_d = resp_rdy_q;
        end
    end

    // Receiver registers including the two-flop RX synchronizer and edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_bit_q   <= 4'd0;
            rx_cnt_q   <= CNT_ZERO;
            rx_shift_q <= 8'h00;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_busy_q  <= rx_busy_d;
            rx_bit_q   <= rx_bit_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX       = tx_q;
    assign frm_snt  = frm_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master, run with a shortened bit period so every
// scenario fits in a short simulation. Glitch length is scaled to that period.
module tb_comm_master;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        snd_cmd;
    logic        clr_resp_rdy;
    logic        RX;
    logic        TX;
    logic        frm_snt;
    logic [7:0]  resp;
    logic        resp_rdy;

    comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
        .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .frm_snt(frm_snt),
        .resp(resp), .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference UART decoder on TX: every byte seen goes into mon_q.
    logic [7:0] mon_q[$];
    int         mon_stop_err = 0;
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge TX);
            repeat (B / 2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(posedge clk);
                #1;
                b[i] = TX;
            end
            repeat (B) @(posedge clk);
            #1;
            if (TX !== 1'b1) mon_stop_err++;
            mon_q.push_back(b);
        end
    end

    int frm_rise = 0;
    always @(posedge frm_snt) frm_rise++;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;
    vec_t vecs[4];

    // Capture a frame, scramble the inputs afterwards, and wait for frm_snt.
    task automatic send_frame(input logic [7:0] c, input logic [15:0] d, output int lat);
        @(negedge clk);
        cmd = c; data = d; snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        cmd = ~c; data = ~d;
        check("frm_snt_clear_on_snd", frm_snt, 1'b0);
        check("tx_start_next_clock", TX, 1'b0);
        lat = 0;
        while (frm_snt !== 1'b1 && lat < 40 * B) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input int lat);
        logic [7:0] exp_b[3];
        logic [7:0] got;
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
        check("frm_latency", lat, (lat >= 30 * B && lat <= 30 * B + 2) ? lat : 30 * B + 1);
        check("frame_byte_count", mon_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            got = (k < mon_q.size()) ? mon_q[k] : 8'hxx;
            check("frame_byte", got, exp_b[k]);
        end
        check("stop_bits", mon_stop_err, 0);
        mon_q.delete();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
    endtask

    initial begin : main
        int         lat;
        int         rise0;
        int         lows;
        logic [7:0] model_resp;
        logic [7:0] rb;
        logic [7:0] rc;
        logic [15:0] rd;

        vecs[0] = '{c: 8'h20, d: 16'h0060, e0: 8'h20, e1: 8'h00, e2: 8'h60};
        vecs[1] = '{c: 8'h43, d: 16'h0076, e0: 8'h43, e1: 8'h00, e2: 8'h76};
        vecs[2] = '{c: 8'hFF, d: 16'hFFFF, e0: 8'hFF, e1: 8'hFF, e2: 8'hFF};
        vecs[3] = '{c: 8'h93, d: 16'h0421, e0: 8'h93, e1: 8'h04, e2: 8'h21};

        rst = 1'b1; cmd = 8'h00; data = 16'h0000; snd_cmd = 1'b0;
        clr_resp_rdy = 1'b0; RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", TX, 1'b1);
        check("reset_frm_snt", frm_snt, 1'b0);
        check("reset_resp", resp, 8'h00);
        check("reset_resp_rdy", resp_rdy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames, each started after the previous frm_snt.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].c, vecs[v].d, lat);
            check_frame(vecs[v].e0, vecs[v].e1, vecs[v].e2, lat);
            repeat (B) @(posedge clk);
            #1;
            check("frm_snt_sticky", frm_snt, 1'b1);
        end

        // Busy: a snd_cmd during the data-high byte must be ignored.
        rise0 = frm_rise;
        fork
            send_frame(8'h3C, 16'h1234, lat);
            begin
                repeat (15 * B) @(negedge clk);
                cmd = 8'h55; data = 16'hAAAA; snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join
        check_frame(8'h3C, 8'h12, 8'h34, lat);
        repeat (12 * B) @(posedge clk);
        #1;
        check("busy_single_rise", frm_rise - rise0, 1);
        check("busy_no_new_frame", mon_q.size(), 0);
        check("busy_frm_snt_held", frm_snt, 1'b1);

        // Reset in the middle of a start bit.
        @(negedge clk);
        cmd = 8'hA5; data = 16'h5A5A; snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        repeat (B / 4) @(posedge clk);
        #2;
        check("pre_reset_tx_low", TX, 1'b0);
        rst = 1'b1;
        #1;
        check("reset_mid_tx", TX, 1'b1);
        check("reset_mid_frm_snt", frm_snt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 12 * B; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        check("reset_mid_idle_tx", lows, 0);
        check("reset_mid_no_frm", frm_snt, 1'b0);
        mon_q.delete();

        // Response byte and clear.
        rx_byte(8'hA5);
        check("rx_resp", resp, 8'hA5);
        check("rx_rdy", resp_rdy, 1'b1);
        pulse_clr();
        check("rx_clr_rdy", resp_rdy, 1'b0);
        check("rx_clr_keeps_resp", resp, 8'hA5);

        // New start bit clears an unconsumed resp_rdy.
        rx_byte(8'h3E);
        check("rx_rdy2", resp_rdy, 1'b1);
        fork
            rx_byte(8'hC1);
            begin
                repeat (B / 2) @(negedge clk);
                check("rx_start_clears_rdy", resp_rdy, 1'b0);
                check("rx_resp_held_mid", resp, 8'h3E);
            end
        join
        check("rx_resp3", resp, 8'hC1);
        check("rx_rdy3", resp_rdy, 1'b1);
        model_resp = 8'hC1;
        pulse_clr();

        // Short low pulse: rejected as a glitch.
        @(negedge clk);
        RX = 1'b0;
        repeat (6) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("glitch_no_rdy", resp_rdy, 1'b0);
        check("glitch_resp_kept", resp, model_resp);

        // Random responses against the last-completed-byte model.
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(255, 0));
            rx_byte(rb);
            model_resp = rb;
            check("rand_rx_resp", resp, model_resp);
            check("rand_rx_rdy", resp_rdy, 1'b1);
            if (i % 2 == 0) begin
                pulse_clr();
                check("rand_rx_clr", resp_rdy, 1'b0);
            end
        end

        // Random frames.
        for (int i = 0; i < 3; i++) begin
            rc = 8'($urandom_range(255, 0));
            rd = 16'($urandom_range(65535, 0));
            send_frame(rc, rd, lat);
            check_frame(rc, rd[15:8], rd[7:0], lat);
        end

        // Concurrent transmit and receive.
        pulse_clr();
        rc = 8'($urandom_range(255, 0));
        rd = 16'($urandom_range(65535, 0));
        rb = 8'($urandom_range(255, 0));
        fork
            send_frame(rc, rd, lat);
            begin
                repeat (3 * B) @(negedge clk);
                rx_byte(rb);
            end
        join
        check_frame(rc, rd[15:8], rd[7:0], lat);
        check("concurrent_resp", resp, rb);
        check("concurrent_rdy", resp_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
